// File: rtl/i2c_target_if.sv
// Pin-level and fabric-side signals of the I2C target.
// slave = the target itself; master = the pads plus the fabric that feeds/consumes bytes.
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_target.sv
// Oversampling I2C target with fixed 7-bit address; pin-to-action latency SYNC_STAGES+1 clk.
// Write backpressure: rx_ready low at a byte's 8th bit NACKs it and drops the rest of the transfer.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  i2c_target_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_cond, stop_cond;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_dly_q;
  assign scl_fall   = ~scl_s & scl_dly_q;
  assign sda_rise   = sda_s & ~sda_dly_q;
  assign sda_fall   = ~sda_s & sda_dly_q;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign rx_byte    = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;

    // Bus conditions win over whatever byte/bit phase we thought we were in.
    if (start_cond) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_cond) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == ADDR) begin
                state_d  = S_ADDR_ACK;
                busy_d   = 1'b1;
                rw_d     = rx_byte[0];
                tx_req_d = rx_byte[0];
                phase_d  = 1'b0;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                // Keep the byte pre-shifted so shift_q[7] is always the next bit out.
                shift_d  = {bus.tx_data[6:0], 1'b0};
                sda_oe_d = ~bus.tx_data[7];
                state_d  = S_READ;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              ack_d      = bus.rx_ready;
              phase_d    = 1'b0;
              state_d    = S_WRITE_ACK;
            end
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = ack_q;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (ack_q) begin
                state_d = S_WRITE;
              end else begin
                state_d = S_WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end
        S_READ: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_READ_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d = S_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && phase_q) begin
            shift_d   = {bus.tx_data[6:0], 1'b0};
            sda_oe_d  = ~bus.tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = S_READ;
          end
        end
        S_WAIT_STOP: sda_oe_d = 1'b0;
        default:     state_d  = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master against i2c_target with an open-drain SDA model and a byte-level reference model.
module tb_i2c_target;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_target_if bus ();

  i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_pool [64];
  logic [7:0] rx_obs [$];
  int         tx_cnt = 0;
  int         clash  = 0;
  int         oe_cnt = 0;
  int         bad_oe = 0;
  logic [7:0] wdat [4];
  logic       wrdy [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fabric side: hand out pool bytes in order on every tx_req, log every rx byte.
  initial begin : fabric_mon
    logic oe_prev;
    oe_prev = 1'b0;
    bus.tx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rx_valid) rx_obs.push_back(bus.rx_data);
      if (bus.tx_req) begin
        bus.tx_data = tx_pool[tx_cnt & 63];
        tx_cnt++;
      end
      if (bus.rx_valid && bus.tx_req) clash++;
      if (bus.sda_oe) oe_cnt++;
      if (bus.sda_oe && !oe_prev && scl_m) bad_oe++;
      oe_prev = bus.sda_oe;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    if (!scl_m) begin
      waitc(Q); sda_m = 1'b1;
      waitc(Q); scl_m = 1'b1;
    end
    waitc(Q); sda_m = 1'b0;
    waitc(Q); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    waitc(Q); sda_m = 1'b0;
    waitc(Q); scl_m = 1'b1;
    waitc(Q); sda_m = 1'b1;
    waitc(2 * Q);
  endtask

  task automatic bit_xfer(input logic drv, output logic smp);
    waitc(Q); sda_m = drv;
    waitc(Q); scl_m = 1'b1;
    waitc(Q); smp = bus.sda_in;
    waitc(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(~mack, s);
  endtask

  // One frame: (repeated) START, address, n bytes from wdat/wrdy or read back, optional STOP.
  task automatic frame(input logic [6:0] a, input logic rw, input int n,
                       input logic rep, input logic with_stop, input string tag);
    int         rx_base, tx_base, oe_base;
    logic       match, ack, alive;
    logic [7:0] b;
    logic [7:0] exp_rx [$];
    rx_base = rx_obs.size();
    tx_base = tx_cnt;
    oe_base = oe_cnt;
    match   = (a == 7'h50);
    do_start();
    if (rep) check({tag, ":busy_sr"}, bus.busy, 1);
    send_byte({a, rw}, ack);
    check({tag, ":addr_ack"}, ack, match);
    check({tag, ":busy_addr"}, bus.busy, match | rep);
    if (!rw) begin
      alive = match;
      for (int i = 0; i < n; i++) begin
        bus.rx_ready = wrdy[i];
        send_byte(wdat[i], ack);
        check({tag, ":data_ack"}, ack, alive & wrdy[i]);
        if (alive) exp_rx.push_back(wdat[i]);
        alive = alive & wrdy[i];
      end
      bus.rx_ready = 1'b1;
    end else if (match) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i != n - 1, b);
        check({tag, ":rd_byte"}, b, tx_pool[(tx_base + i) & 63]);
      end
      check({tag, ":busy_nack"}, bus.busy, 0);
      check({tag, ":oe_nack"}, bus.sda_oe, 0);
    end
    if (with_stop) begin
      do_stop();
      check({tag, ":busy_stop"}, bus.busy, 0);
      check({tag, ":oe_stop"}, bus.sda_oe, 0);
    end
    check({tag, ":rx_cnt"}, rx_obs.size() - rx_base, exp_rx.size());
    for (int i = 0; i < exp_rx.size() && rx_base + i < rx_obs.size(); i++)
      check({tag, ":rx_byte"}, rx_obs[rx_base + i], exp_rx[i]);
    if (exp_rx.size() > 0) check({tag, ":rx_hold"}, bus.rx_data, exp_rx[exp_rx.size() - 1]);
    check({tag, ":tx_req_cnt"}, tx_cnt - tx_base, (match && rw) ? n : 0);
    if (!match) check({tag, ":oe_quiet"}, oe_cnt - oe_base, 0);
  endtask

  initial begin : main
    logic       ack;
    logic [6:0] a;
    logic       rw;
    int         n;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 64; i++) tx_pool[i] = 8'($urandom);

    waitc(3);
    check("rst:sda_oe", bus.sda_oe, 0);
    check("rst:rx_data", bus.rx_data, 8'h00);
    check("rst:rx_valid", bus.rx_valid, 0);
    check("rst:tx_req", bus.tx_req, 0);
    check("rst:busy", bus.busy, 0);
    rst = 1'b1;
    waitc(5);

    wdat[0] = 8'h3C; wrdy[0] = 1'b1;
    frame(7'h50, 1'b0, 1, 1'b0, 1'b1, "t1_write");

    tx_pool[tx_cnt & 63] = 8'h5A;
    tx_pool[(tx_cnt + 1) & 63] = 8'hC3;
    frame(7'h50, 1'b1, 2, 1'b0, 1'b1, "t2_read");

    wdat[0] = 8'hFF; wrdy[0] = 1'b1;
    frame(7'h11, 1'b0, 1, 1'b0, 1'b1, "t3_mismatch");

    wdat[0] = 8'h07; wrdy[0] = 1'b1;
    frame(7'h50, 1'b0, 1, 1'b0, 1'b0, "t4_wr");
    frame(7'h50, 1'b1, 1, 1'b1, 1'b1, "t4_sr_rd");

    wdat[0] = 8'h11; wrdy[0] = 1'b1;
    wdat[1] = 8'h22; wrdy[1] = 1'b0;
    wdat[2] = 8'h33; wrdy[2] = 1'b1;
    frame(7'h50, 1'b0, 3, 1'b0, 1'b1, "t5_full");

    // Abort a read while the target is pulling SDA low, then check recovery.
    tx_pool[tx_cnt & 63] = 8'h00;
    do_start();
    send_byte({7'h50, 1'b1}, ack);
    check("t6:addr_ack", ack, 1);
    waitc(4);
    check("t6:oe_driving", bus.sda_oe, 1);
    rst = 1'b0;
    #1;
    check("t6:oe_async", bus.sda_oe, 0);
    check("t6:busy_async", bus.busy, 0);
    waitc(3);
    rst = 1'b1;
    sda_m = 1'b1;
    waitc(Q); scl_m = 1'b1;
    waitc(2 * Q);
    wdat[0] = 8'h96; wrdy[0] = 1'b1;
    frame(7'h50, 1'b0, 1, 1'b0, 1'b1, "t6_after");

    for (int t = 0; t < 25; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        wdat[k] = 8'($urandom);
        wrdy[k] = ($urandom_range(0, 3) != 0);
      end
      frame(a, rw, n, 1'b0, 1'b1, "rnd");
    end

    check("inv:rx_tx_clash", clash, 0);
    check("inv:oe_rise_scl_high", bad_oe, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
